// File: rtl/huffman_decoder.sv
// Serial JPEG AC-luminance Huffman decoder (fixed ITU-T T.81 Table K.5).
// Latency: symbol_valid_out rises the cycle after the last code/amplitude bit is accepted.
// Backpressure: bit_ready_out drops while a decoded symbol waits for symbol_ready_in.
//
// Ports:
//   clk_in, rst_in               clock, synchronous active-high reset
//   bit_in/bit_valid_in/bit_ready_out     MSB-first entropy-coded bit stream
//   run_out/size_out/coef_out/eob_out     decoded symbol fields
//   symbol_valid_out/symbol_ready_in      symbol handshake
//   err_out                      one-cycle pulse when 16 bits match no code
module huffman_decoder #(
  parameter int COEF_W = 11
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     bit_in,
  input  logic                     bit_valid_in,
  output logic                     bit_ready_out,
  output logic [3:0]               run_out,
  output logic [3:0]               size_out,
  output logic signed [COEF_W-1:0] coef_out,
  output logic                     eob_out,
  output logic                     symbol_valid_out,
  input  logic                     symbol_ready_in,
  output logic                     err_out
);

  typedef enum logic [1:0] {
    CODE = 2'd0,
    AMP  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Canonical decode parameters for one code length.
  typedef struct packed {
    logic        has;      // at least one code of this length exists
    logic [15:0] mincode;
    logic [15:0] maxcode;
    logic [7:0]  valptr;   // HUFFVAL index of the first code of this length
  } len_tab_t;

  // MINCODE/MAXCODE/VALPTR derived from BITS = 0,2,1,3,3,2,4,3,5,5,4,4,0,0,1,125.
  function automatic len_tab_t len_tab(input logic [4:0] len);
    len_tab_t t;
    case (len)
      5'd1:    t = '{1'b0, 16'd0,     16'd0,     8'd0};
      5'd2:    t = '{1'b1, 16'd0,     16'd1,     8'd0};
      5'd3:    t = '{1'b1, 16'd4,     16'd4,     8'd2};
      5'd4:    t = '{1'b1, 16'd10,    16'd12,    8'd3};
      5'd5:    t = '{1'b1, 16'd26,    16'd28,    8'd6};
      5'd6:    t = '{1'b1, 16'd58,    16'd59,    8'd9};
      5'd7:    t = '{1'b1, 16'd120,   16'd123,   8'd11};
      5'd8:    t = '{1'b1, 16'd248,   16'd250,   8'd15};
      5'd9:    t = '{1'b1, 16'd502,   16'd506,   8'd18};
      5'd10:   t = '{1'b1, 16'd1014,  16'd1018,  8'd23};
      5'd11:   t = '{1'b1, 16'd2038,  16'd2041,  8'd28};
      5'd12:   t = '{1'b1, 16'd4084,  16'd4087,  8'd32};
      5'd13:   t = '{1'b0, 16'd0,     16'd0,     8'd0};
      5'd14:   t = '{1'b0, 16'd0,     16'd0,     8'd0};
      5'd15:   t = '{1'b1, 16'd32704, 16'd32704, 8'd36};
      5'd16:   t = '{1'b1, 16'd65410, 16'd65534, 8'd37};
      default: t = '{1'b0, 16'd0,     16'd0,     8'd0};
    endcase
    return t;
  endfunction

  // HUFFVAL ROM, 162 entries in code order. No entry has a size nibble above 10.
  function automatic logic [7:0] huffval(input logic [7:0] idx);
    logic [7:0] v;
    case (idx)
      8'd0:   v = 8'h01; 8'd1:   v = 8'h02; 8'd2:   v = 8'h03; 8'd3:   v = 8'h00; 8'd4:   v = 8'h04; 8'd5:   v = 8'h11; 8'd6:   v = 8'h05; 8'd7:   v = 8'h12;
      8'd8:   v = 8'h21; 8'd9:   v = 8'h31; 8'd10:  v = 8'h41; 8'd11:  v = 8'h06; 8'd12:  v = 8'h13; 8'd13:  v = 8'h51; 8'd14:  v = 8'h61; 8'd15:  v = 8'h07;
      8'd16:  v = 8'h22; 8'd17:  v = 8'h71; 8'd18:  v = 8'h14; 8'd19:  v = 8'h32; 8'd20:  v = 8'h81; 8'd21:  v = 8'h91; 8'd22:  v = 8'ha1; 8'd23:  v = 8'h08;
      8'd24:  v = 8'h23; 8'd25:  v = 8'h42; 8'd26:  v = 8'hb1; 8'd27:  v = 8'hc1; 8'd28:  v = 8'h15; 8'd29:  v = 8'h52; 8'd30:  v = 8'hd1; 8'd31:  v = 8'hf0;
      8'd32:  v = 8'h24; 8'd33:  v = 8'h33; 8'd34:  v = 8'h62; 8'd35:  v = 8'h72; 8'd36:  v = 8'h82; 8'd37:  v = 8'h09; 8'd38:  v = 8'h0a; 8'd39:  v = 8'h16;
      8'd40:  v = 8'h17; 8'd41:  v = 8'h18; 8'd42:  v = 8'h19; 8'd43:  v = 8'h1a; 8'd44:  v = 8'h25; 8'd45:  v = 8'h26; 8'd46:  v = 8'h27; 8'd47:  v = 8'h28;
      8'd48:  v = 8'h29; 8'd49:  v = 8'h2a; 8'd50:  v = 8'h34; 8'd51:  v = 8'h35; 8'd52:  v = 8'h36; 8'd53:  v = 8'h37; 8'd54:  v = 8'h38; 8'd55:  v = 8'h39;
      8'd56:  v = 8'h3a; 8'd57:  v = 8'h43; 8'd58:  v = 8'h44; 8'd59:  v = 8'h45; 8'd60:  v = 8'h46; 8'd61:  v = 8'h47; 8'd62:  v = 8'h48; 8'd63:  v = 8'h49;
      8'd64:  v = 8'h4a; 8'd65:  v = 8'h53; 8'd66:  v = 8'h54; 8'd67:  v = 8'h55; 8'd68:  v = 8'h56; 8'd69:  v = 8'h57; 8'd70:  v = 8'h58; 8'd71:  v = 8'h59;
      8'd72:  v = 8'h5a; 8'd73:  v = 8'h63; 8'd74:  v = 8'h64; 8'd75:  v = 8'h65; 8'd76:  v = 8'h66; 8'd77:  v = 8'h67; 8'd78:  v = 8'h68; 8'd79:  v = 8'h69;
      8'd80:  v = 8'h6a; 8'd81:  v = 8'h73; 8'd82:  v = 8'h74; 8'd83:  v = 8'h75; 8'd84:  v = 8'h76; 8'd85:  v = 8'h77; 8'd86:  v = 8'h78; 8'd87:  v = 8'h79;
      8'd88:  v = 8'h7a; 8'd89:  v = 8'h83; 8'd90:  v = 8'h84; 8'd91:  v = 8'h85; 8'd92:  v = 8'h86; 8'd93:  v = 8'h87; 8'd94:  v = 8'h88; 8'd95:  v = 8'h89;
      8'd96:  v = 8'h8a; 8'd97:  v = 8'h92; 8'd98:  v = 8'h93; 8'd99:  v = 8'h94; 8'd100: v = 8'h95; 8'd101: v = 8'h96; 8'd102: v = 8'h97; 8'd103: v = 8'h98;
      8'd104: v = 8'h99; 8'd105: v = 8'h9a; 8'd106: v = 8'ha2; 8'd107: v = 8'ha3; 8'd108: v = 8'ha4; 8'd109: v = 8'ha5; 8'd110: v = 8'ha6; 8'd111: v = 8'ha7;
      8'd112: v = 8'ha8; 8'd113: v = 8'ha9; 8'd114: v = 8'haa; 8'd115: v = 8'hb2; 8'd116: v = 8'hb3; 8'd117: v = 8'hb4; 8'd118: v = 8'hb5; 8'd119: v = 8'hb6;
      8'd120: v = 8'hb7; 8'd121: v = 8'hb8; 8'd122: v = 8'hb9; 8'd123: v = 8'hba; 8'd124: v = 8'hc2; 8'd125: v = 8'hc3; 8'd126: v = 8'hc4; 8'd127: v = 8'hc5;
      8'd128: v = 8'hc6; 8'd129: v = 8'hc7; 8'd130: v = 8'hc8; 8'd131: v = 8'hc9; 8'd132: v = 8'hca; 8'd133: v = 8'hd2; 8'd134: v = 8'hd3; 8'd135: v = 8'hd4;
      8'd136: v = 8'hd5; 8'd137: v = 8'hd6; 8'd138: v = 8'hd7; 8'd139: v = 8'hd8; 8'd140: v = 8'hd9; 8'd141: v = 8'hda; 8'd142: v = 8'he1; 8'd143: v = 8'he2;
      8'd144: v = 8'he3; 8'd145: v = 8'he4; 8'd146: v = 8'he5; 8'd147: v = 8'he6; 8'd148: v = 8'he7; 8'd149: v = 8'he8; 8'd150: v = 8'he9; 8'd151: v = 8'hea;
      8'd152: v = 8'hf1; 8'd153: v = 8'hf2; 8'd154: v = 8'hf3; 8'd155: v = 8'hf4; 8'd156: v = 8'hf5; 8'd157: v = 8'hf6; 8'd158: v = 8'hf7; 8'd159: v = 8'hf8;
      8'd160: v = 8'hf9; 8'd161: v = 8'hfa;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Registered state
  state_t                    state_q, state_d;
  logic [14:0]               code_q, code_d;     // a 16-bit code always resolves, so 15 bits suffice
  logic [4:0]                len_q, len_d;
  logic [14:0]               amp_q, amp_d;
  logic [3:0]                amp_cnt_q, amp_cnt_d;
  logic [3:0]                run_q, run_d;
  logic [3:0]                size_q, size_d;
  logic signed [COEF_W-1:0]  coef_q, coef_d;
  logic                      eob_q, eob_d;
  logic                      err_q, err_d;

  // Datapath helpers
  logic                      bit_acc;
  logic [15:0]               code_shift;
  logic [4:0]                len_inc;
  len_tab_t                  tab;
  logic [7:0]                sym;
  logic                      match;
  logic [15:0]               amp_shift;
  logic [3:0]                cnt_inc;
  logic [16:0]               amp_mask;
  logic signed [16:0]        coef_full;

  assign bit_ready_out    = (state_q != OUT);
  assign symbol_valid_out = (state_q == OUT);
  assign bit_acc          = bit_valid_in && bit_ready_out;

  // Candidate code including the bit on the wire; only committed when accepted.
  assign code_shift = {code_q, bit_in};
  assign len_inc    = len_q + 5'd1;
  assign tab        = len_tab(len_inc);
  // Canonical property: an unmatched prefix is always >= MINCODE of the next length,
  // so the ROM offset is valid whenever match is true.
  assign match      = tab.has && (code_shift <= tab.maxcode);
  assign sym        = huffval(tab.valptr + 8'(code_shift - tab.mincode));

  // Amplitude: leading 1 means positive as-is, leading 0 means r - (2^size - 1).
  assign amp_shift  = {amp_q, bit_in};
  assign cnt_inc    = amp_cnt_q + 4'd1;
  assign amp_mask   = (17'd1 << size_q) - 17'd1;
  assign coef_full  = amp_shift[size_q - 4'd1] ? {1'b0, amp_shift}
                                               : ({1'b0, amp_shift} - amp_mask);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    len_d     = len_q;
    amp_d     = amp_q;
    amp_cnt_d = amp_cnt_q;
    run_d     = run_q;
    size_d    = size_q;
    coef_d    = coef_q;
    eob_d     = eob_q;
    err_d     = 1'b0;

    case (state_q)
      CODE: begin
        if (bit_acc) begin
          if (match) begin
            code_d = '0;
            len_d  = '0;
            run_d  = sym[7:4];
            size_d = sym[3:0];
            if (sym[3:0] == 4'd0) begin
              coef_d  = '0;
              eob_d   = (sym == 8'h00);
              state_d = OUT;
            end else begin
              amp_d     = '0;
              amp_cnt_d = '0;
              state_d   = AMP;
            end
          end else if (len_inc == 5'd16) begin
            // No 16-bit prefix matched: drop it and resynchronise on the next bit.
            err_d  = 1'b1;
            code_d = '0;
            len_d  = '0;
          end else begin
            code_d = code_shift[14:0];
            len_d  = len_inc;
          end
        end
      end

      AMP: begin
        if (bit_acc) begin
          amp_d     = amp_shift[14:0];
          amp_cnt_d = cnt_inc;
          if (cnt_inc == size_q) begin
            coef_d  = COEF_W'(coef_full);
            eob_d   = 1'b0;
            state_d = OUT;
          end
        end
      end

      OUT: begin
        if (symbol_ready_in) begin
          code_d  = '0;
          len_d   = '0;
          state_d = CODE;
        end
      end

      default: state_d = CODE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= CODE;
      code_q    <= '0;
      len_q     <= '0;
      amp_q     <= '0;
      amp_cnt_q <= '0;
      run_q     <= '0;
      size_q    <= '0;
      coef_q    <= '0;
      eob_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      len_q     <= len_d;
      amp_q     <= amp_d;
      amp_cnt_q <= amp_cnt_d;
      run_q     <= run_d;
      size_q    <= size_d;
      coef_q    <= coef_d;
      eob_q     <= eob_d;
      err_q     <= err_d;
    end
  end

  assign run_out  = run_q;
  assign size_out = size_q;
  assign coef_out = coef_q;
  assign eob_out  = eob_q;
  assign err_out  = err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: encodes symbols with a canonical-code encoder model,
// streams the bits with random valid/ready gaps and scores decoded symbols/errors in order.
// Directed vectors cover reset, EOB/ZRL, negative amplitudes, invalid code, stall and mid-symbol reset.
module tb_huffman_decoder;
  localparam int COEF_W = 11;

  logic                     clk_in;
  logic                     rst_in;
  logic                     bit_in;
  logic                     bit_valid_in;
  logic                     bit_ready_out;
  logic [3:0]               run_out;
  logic [3:0]               size_out;
  logic signed [COEF_W-1:0] coef_out;
  logic                     eob_out;
  logic                     symbol_valid_out;
  logic                     symbol_ready_in;
  logic                     err_out;

  huffman_decoder #(.COEF_W(COEF_W)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .bit_in           (bit_in),
    .bit_valid_in     (bit_valid_in),
    .bit_ready_out    (bit_ready_out),
    .run_out          (run_out),
    .size_out         (size_out),
    .coef_out         (coef_out),
    .eob_out          (eob_out),
    .symbol_valid_out (symbol_valid_out),
    .symbol_ready_in  (symbol_ready_in),
    .err_out          (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    bit is_err;
    int run;
    int size;
    int coef;
    bit eob;
  } ev_t;

  bit  bitq[$];
  ev_t evq[$];
  int  num_checks;
  int  num_errors;

  int bits_tab [16] = '{0, 2, 1, 3, 3, 2, 4, 3, 5, 5, 4, 4, 0, 0, 1, 125};
  logic [7:0] hv [162] = '{
    8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12, 8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
    8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'ha1, 8'h08, 8'h23, 8'h42, 8'hb1, 8'hc1, 8'h15, 8'h52, 8'hd1, 8'hf0,
    8'h24, 8'h33, 8'h62, 8'h72, 8'h82, 8'h09, 8'h0a, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1a, 8'h25, 8'h26, 8'h27, 8'h28,
    8'h29, 8'h2a, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3a, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
    8'h4a, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5a, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
    8'h6a, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7a, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
    8'h8a, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98, 8'h99, 8'h9a, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
    8'ha8, 8'ha9, 8'haa, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6, 8'hb7, 8'hb8, 8'hb9, 8'hba, 8'hc2, 8'hc3, 8'hc4, 8'hc5,
    8'hc6, 8'hc7, 8'hc8, 8'hc9, 8'hca, 8'hd2, 8'hd3, 8'hd4, 8'hd5, 8'hd6, 8'hd7, 8'hd8, 8'hd9, 8'hda, 8'he1, 8'he2,
    8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 8'he8, 8'he9, 8'hea, 8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7, 8'hf8,
    8'hf9, 8'hfa
  };
  int code_of [162];
  int len_of  [162];

  task automatic check_val(input string tag, input int got, input int exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Canonical code assignment: consecutive codes per length, doubling between lengths.
  task automatic build_codes();
    int c;
    int k;
    c = 0;
    k = 0;
    for (int l = 1; l <= 16; l++) begin
      for (int n = 0; n < bits_tab[l-1]; n++) begin
        code_of[k] = c;
        len_of[k]  = l;
        k++;
        c++;
      end
      c = c << 1;
    end
  endtask

  task automatic push_bits(input string s);
    for (int i = 0; i < s.len(); i++) bitq.push_back(s[i] == 8'h31);
  endtask

  task automatic expect_sym(input int run, input int size, input int coef, input bit eob);
    ev_t e;
    e.is_err = 1'b0;
    e.run    = run;
    e.size   = size;
    e.coef   = coef;
    e.eob    = eob;
    evq.push_back(e);
  endtask

  task automatic expect_err();
    ev_t e;
    e.is_err = 1'b1;
    e.run    = 0;
    e.size   = 0;
    e.coef   = 0;
    e.eob    = 1'b0;
    evq.push_back(e);
  endtask

  // Encoder model: Huffman code, then JPEG amplitude bits (negative values as c + 2^s - 1).
  task automatic encode(input int idx, input int c);
    int s;
    int v;
    s = int'(hv[idx][3:0]);
    for (int b = len_of[idx] - 1; b >= 0; b--) bitq.push_back(((code_of[idx] >> b) & 1) == 1);
    if (s > 0) begin
      v = (c > 0) ? c : c + (1 << s) - 1;
      for (int b = s - 1; b >= 0; b--) bitq.push_back(((v >> b) & 1) == 1);
    end
    expect_sym(int'(hv[idx][7:4]), s, c, hv[idx] == 8'h00);
  endtask

  // mode 0: random valid/ready; 1: always valid/ready; 2: ready held low 10 cycles per symbol.
  task automatic run_stream(input int mode, input int budget);
    int  cyc;
    int  low_cnt;
    bit  hold;
    int  pr, ps, pc, pe;
    ev_t e;
    cyc = 0; low_cnt = 0; hold = 1'b0;
    pr = 0; ps = 0; pc = 0; pe = 0;
    while ((bitq.size() != 0 || evq.size() != 0) && cyc < budget) begin
      @(negedge clk_in);
      cyc++;
      if (err_out) begin
        if (evq.size() == 0) check_val("err_spurious", 1, 0);
        else begin
          e = evq.pop_front();
          check_val("err_order", int'(e.is_err), 1);
        end
      end
      if (hold) begin
        check_val("hold_valid", int'(symbol_valid_out), 1);
        check_val("hold_run", int'(run_out), pr);
        check_val("hold_size", int'(size_out), ps);
        check_val("hold_coef", int'(coef_out), pc);
        check_val("hold_eob", int'(eob_out), pe);
      end
      if (symbol_valid_out) check_val("bit_ready_in_out", int'(bit_ready_out), 0);
      else                  check_val("bit_ready_decoding", int'(bit_ready_out), 1);

      case (mode)
        0:       symbol_ready_in = ($urandom_range(0, 1) == 1);
        2:       symbol_ready_in = !(symbol_valid_out && low_cnt < 10);
        default: symbol_ready_in = 1'b1;
      endcase
      if (mode == 2 && symbol_valid_out && !symbol_ready_in) low_cnt++;
      bit_valid_in = (bitq.size() != 0) && (mode != 0 || $urandom_range(0, 3) != 0);
      bit_in       = (bitq.size() != 0) ? bitq[0] : 1'b0;

      if (symbol_valid_out && symbol_ready_in) begin
        hold    = 1'b0;
        low_cnt = 0;
        if (evq.size() == 0) check_val("sym_spurious", 1, 0);
        else begin
          e = evq.pop_front();
          check_val("sym_kind", int'(e.is_err), 0);
          check_val("sym_run", int'(run_out), e.run);
          check_val("sym_size", int'(size_out), e.size);
          check_val("sym_coef", int'(coef_out), e.coef);
          check_val("sym_eob", int'(eob_out), int'(e.eob));
        end
      end else begin
        hold = symbol_valid_out;
        pr = int'(run_out); ps = int'(size_out); pc = int'(coef_out); pe = int'(eob_out);
      end
      if (bit_valid_in && bit_ready_out) void'(bitq.pop_front());
    end
    bit_valid_in = 1'b0;
    check_val("stream_drained", bitq.size() + evq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, int'(symbol_valid_out), 0);
    check_val({tag, "_err"}, int'(err_out), 0);
    check_val({tag, "_eob"}, int'(eob_out), 0);
    check_val({tag, "_run"}, int'(run_out), 0);
    check_val({tag, "_size"}, int'(size_out), 0);
    check_val({tag, "_coef"}, int'(coef_out), 0);
    check_val({tag, "_bit_ready"}, int'(bit_ready_out), 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int s;
    int mag;
    int c;
    num_checks = 0;
    num_errors = 0;
    build_codes();
    rst_in = 1'b1; bit_in = 1'b0; bit_valid_in = 1'b0; symbol_ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check_reset_outputs("reset");
    rst_in = 1'b0;

    // Directed vectors with hand-computed expectations.
    push_bits("001");               expect_sym(0, 1, 1, 1'b0);
    push_bits("000");               expect_sym(0, 1, -1, 1'b0);
    push_bits("1010");              expect_sym(0, 0, 0, 1'b1);
    push_bits("11111111001");       expect_sym(15, 0, 0, 1'b0);
    push_bits("100110");            expect_sym(0, 3, 6, 1'b0);
    push_bits("100010");            expect_sym(0, 3, -5, 1'b0);
    push_bits("1111111111111111");  expect_err();
    push_bits("0111");              expect_sym(0, 2, 3, 1'b0);
    run_stream(1, 500);

    // Downstream stall: bits stay pending while each symbol waits 10 cycles.
    push_bits("100110");            expect_sym(0, 3, 6, 1'b0);
    push_bits("000");               expect_sym(0, 1, -1, 1'b0);
    push_bits("1010");              expect_sym(0, 0, 0, 1'b1);
    run_stream(2, 500);

    // Reset while collecting amplitude bits of code 100: partial symbol must vanish.
    push_bits("1001");
    run_stream(1, 100);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_reset_outputs("midreset");
    push_bits("001");               expect_sym(0, 1, 1, 1'b0);
    run_stream(1, 100);

    // Random symbols with occasional invalid codes, random valid/ready gaps.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        push_bits("1111111111111111");
        expect_err();
      end else begin
        idx = $urandom_range(0, 161);
        s   = int'(hv[idx][3:0]);
        c   = 0;
        if (s > 0) begin
          mag = $urandom_range((1 << s) - 1, 1 << (s - 1));
          c   = ($urandom_range(0, 1) == 1) ? mag : -mag;
        end
        encode(idx, c);
      end
    end
    run_stream(0, 40000);

    repeat (3) @(negedge clk_in);
    check_val("idle_valid", int'(symbol_valid_out), 0);
    check_val("idle_err", int'(err_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
